// File: rtl/safe_irq_pkg.sv
// safe_irq_pkg: shared types and constants for the safe-mode interrupt front end.
// Source state enum, source indices, register offsets and STATUS bit positions.
package safe_irq_pkg;
    typedef enum logic [1:0] {IDLE, PEND, ACTIVE, WAIT_LOW} src_state_e;
    localparam int SRC_SYNC        = 0;
    localparam int SRC_SW_RESYNC   = 1;
    localparam int SRC_COPY_RESYNC = 2;
    localparam int SRC_DM_SH_SYNC  = 3;
    localparam logic [3:0] OFF_CLAIM    = 4'h0;
    localparam logic [3:0] OFF_COMPLETE = 4'h4;
    localparam logic [3:0] OFF_STATUS   = 4'h8;
    localparam int STATUS_PEND_LSB    = 0;
    localparam int STATUS_ACTIVE_LSB  = 4;
    localparam int STATUS_TIMEOUT_BIT = 8;
endpackage

// File: rtl/safe_irq_src.sv
// safe_irq_src: claim/complete FSM for one (hart, source) interrupt request.
module safe_irq_src
    import safe_irq_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src,
    input  logic claim,
    input  logic complete,
    output logic irq,
    output logic active,
    output logic pending
);
    src_state_e r_state, w_state_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // A claim beats a same-cycle withdrawal; WAIT_LOW blocks re-triggering on a held level.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     w_state_nxt = src ? PEND : IDLE;
            PEND:     w_state_nxt = claim ? ACTIVE : (src ? PEND : IDLE);
            ACTIVE:   w_state_nxt = complete ? (src ? WAIT_LOW : IDLE) : ACTIVE;
            WAIT_LOW: w_state_nxt = src ? WAIT_LOW : IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    assign pending = r_state == PEND;
    assign active  = r_state == ACTIVE;
    assign irq     = pending;
endmodule

// File: rtl/safe_irq_ctrl.sv
// safe_irq_ctrl: per-hart interrupt front end with claim/complete register port.
// Optional pending-timeout flag built when SAFE_IRQ_TIMEOUT_EN is defined.
module safe_irq_ctrl
    import safe_irq_pkg::*;
#(
    parameter int NHARTS         = 3,
    parameter int NSRC           = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NHARTS-1:0][NSRC-1:0]  src_i,
    output logic [NHARTS-1:0][NSRC-1:0]  irq_o,
    output logic [NHARTS-1:0]            intc_ack_o,
    input  logic [NHARTS-1:0]            reg_req_i,
    input  logic [NHARTS-1:0]            reg_we_i,
    input  logic [NHARTS-1:0][3:0]       reg_addr_i,
    input  logic [NHARTS-1:0][31:0]      reg_wdata_i,
    output logic [NHARTS-1:0][31:0]      reg_rdata_o,
`ifdef SAFE_IRQ_TIMEOUT_EN
    output logic [NHARTS-1:0]            timeout_o,
`endif
    output logic [NHARTS-1:0]            reg_rvalid_o
);
    logic w_unused;
    assign w_unused = ^{reg_wdata_i, TIMEOUT_CYCLES};

    for (genvar h = 0; h < NHARTS; h++) begin : g_hart
        logic [NSRC-1:0] w_claim, w_complete, w_pend, w_act;
        logic            w_wr, w_to, r_rvalid;
        logic [31:0]     w_status, w_rd, r_rdata;

        assign w_wr       = reg_req_i[h] & reg_we_i[h];
        assign w_claim    = (w_wr && reg_addr_i[h] == OFF_CLAIM)    ? reg_wdata_i[h][NSRC-1:0] : '0;
        assign w_complete = (w_wr && reg_addr_i[h] == OFF_COMPLETE) ? reg_wdata_i[h][NSRC-1:0] : '0;

        for (genvar s = 0; s < NSRC; s++) begin : g_src
            safe_irq_src u_src (
                .clk_i    (clk_i),
                .rst_ni   (rst_ni),
                .src      (src_i[h][s]),
                .claim    (w_claim[s]),
                .complete (w_complete[s]),
                .irq      (irq_o[h][s]),
                .active   (w_act[s]),
                .pending  (w_pend[s])
            );
        end

        assign intc_ack_o[h] = |w_act;
        assign w_status = (32'(w_pend) << STATUS_PEND_LSB) | (32'(w_act) << STATUS_ACTIVE_LSB) |
                          (32'(w_to) << STATUS_TIMEOUT_BIT);
        assign w_rd = (reg_addr_i[h] == OFF_CLAIM)    ? 32'(w_pend) :
                      (reg_addr_i[h] == OFF_COMPLETE) ? 32'(w_act)  :
                      (reg_addr_i[h] == OFF_STATUS)   ? w_status    : '0;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_rvalid <= 1'b0;
                r_rdata  <= '0;
            end else begin
                r_rvalid <= reg_req_i[h];
                r_rdata  <= reg_req_i[h] ? w_rd : '0;
            end
        end

        assign reg_rvalid_o[h] = r_rvalid;
        assign reg_rdata_o[h]  = r_rdata;

`ifdef SAFE_IRQ_TIMEOUT_EN
        localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
        logic [CW-1:0] r_cnt, w_cnt_nxt;
        logic          r_to, w_clr, w_expire;

        assign w_cnt_nxt = !(|w_pend) ? '0 : (r_cnt == CW'(TIMEOUT_CYCLES)) ? r_cnt : r_cnt + 1'b1;
        // Fire only on the cycle the threshold is reached so a clear sticks while saturated.
        assign w_expire  = (w_cnt_nxt == CW'(TIMEOUT_CYCLES)) && (r_cnt != CW'(TIMEOUT_CYCLES));
        assign w_clr     = w_wr && reg_addr_i[h] == OFF_STATUS && reg_wdata_i[h][STATUS_TIMEOUT_BIT];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt <= '0;
                r_to  <= 1'b0;
            end else begin
                r_cnt <= w_cnt_nxt;
                r_to  <= (r_to & ~w_clr) | w_expire;
            end
        end

        assign w_to         = r_to;
        assign timeout_o[h] = r_to;
`else
        assign w_to = 1'b0;
`endif
    end
endmodule
